// File: rtl/if_stage_pkg.sv
// Shared constants, types and helpers for the instruction-fetch stage.
package if_stage_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam logic [15:0] STALL_MAX        = 16'hFFFF;

  // What the fetch stage does this cycle, after reset has been excluded.
  typedef enum logic [1:0] {
    FA_FETCH  = 2'd0,
    FA_STALL  = 2'd1,
    FA_HALT   = 2'd2,
    FA_BRANCH = 2'd3
  } fetch_action_e;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Saturating 16-bit increment.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == STALL_MAX) ? STALL_MAX : (val + 16'd1);
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: holds when not loaded, flushes to a bubble.
module if_stage_if_id_reg
  import if_stage_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_load,
  input  logic [INSTR_W-1:0] i_instruction,
  input  logic [31:0]        i_pc_plus4,
  output logic [INSTR_W-1:0] o_instruction,
  output logic [31:0]        o_pc_plus4,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instruction;
  logic [31:0]        r_pc_plus4;
  logic               r_valid;

  // Bubble on reset or flush, capture on load, otherwise hold for a stall.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_instruction <= NOP_WORD;
      r_pc_plus4    <= 32'h0000_0000;
      r_valid       <= 1'b0;
    end else if (i_load) begin
      r_instruction <= i_instruction;
      r_pc_plus4    <= i_pc_plus4;
      r_valid       <= 1'b1;
    end else begin
      r_instruction <= r_instruction;
      r_pc_plus4    <= r_pc_plus4;
      r_valid       <= r_valid;
    end
  end

  assign o_instruction = r_instruction;
  assign o_pc_plus4    = r_pc_plus4;
  assign o_valid       = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, end-of-memory halt, stall counter
// and the IF/ID pipeline register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic [31:0]        i_branch_target,
  input  logic [INSTR_W-1:0] i_instruction,
  output logic [31:0]        o_pc,
  output logic [INSTR_W-1:0] o_if_id_instruction,
  output logic [31:0]        o_if_id_pc_plus4,
  output logic               o_if_id_valid,
  output logic               o_halted,
  output logic [15:0]        o_stall_count
);

  // Fetch limit in bytes, one bit wider than the PC so pc+4 never wraps
  // into a small, in-range value.
  localparam logic [32:0] FETCH_LIMIT = 33'(MEM_WORDS) * 33'd4;

  logic [31:0]   r_pc;
  logic          r_halted;
  logic [15:0]   r_stall_count;

  fetch_action_e w_action;
  logic [31:0]   w_pc_plus4;
  logic          w_at_end;
  logic [31:0]   w_target;
  logic          w_target_in_mem;
  logic [31:0]   w_pc_next;
  logic          w_halted_next;
  logic          w_stall_inc;
  logic          w_flush;
  logic          w_load;

  assign w_pc_plus4      = r_pc + PC_STEP;
  assign w_at_end        = (({1'b0, r_pc} + 33'd4) >= FETCH_LIMIT);
  assign w_target        = align_word(i_branch_target);
  assign w_target_in_mem = ({1'b0, w_target} < FETCH_LIMIT);

  // Resolve the per-cycle priority: branch > halted > stall > fetch.
  always_comb begin
    w_action = FA_FETCH;
    if (i_branch_taken) begin
      w_action = FA_BRANCH;
    end else if (r_halted) begin
      w_action = FA_HALT;
    end else if (i_stall) begin
      w_action = FA_STALL;
    end else begin
      w_action = FA_FETCH;
    end
  end

  // Next PC, halt flag and IF/ID controls for the chosen action.
  always_comb begin
    w_pc_next     = r_pc;
    w_halted_next = r_halted;
    w_flush       = 1'b0;
    w_load        = 1'b0;
    w_stall_inc   = 1'b0;
    case (w_action)
      FA_BRANCH: begin
        w_pc_next     = w_target;
        w_halted_next = w_target_in_mem ? 1'b0 : r_halted;
        w_flush       = 1'b1;
        w_stall_inc   = i_stall;
      end
      FA_HALT: begin
        w_flush = 1'b1;
      end
      FA_STALL: begin
        w_stall_inc = 1'b1;
      end
      FA_FETCH: begin
        w_load = 1'b1;
        if (w_at_end) begin
          w_pc_next     = r_pc;
          w_halted_next = 1'b1;
        end else begin
          w_pc_next     = w_pc_plus4;
          w_halted_next = r_halted;
        end
      end
      default: begin
        w_flush = 1'b1;
      end
    endcase
  end

  // PC, sticky halt flag and saturating stall counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc          <= PC_RESET;
      r_halted      <= 1'b0;
      r_stall_count <= 16'h0000;
    end else begin
      r_pc          <= w_pc_next;
      r_halted      <= w_halted_next;
      r_stall_count <= w_stall_inc ? sat_inc16(r_stall_count) : r_stall_count;
    end
  end

  if_stage_if_id_reg u_if_id_reg (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_flush       (w_flush),
    .i_load        (w_load),
    .i_instruction (i_instruction),
    .i_pc_plus4    (w_pc_plus4),
    .o_instruction (o_if_id_instruction),
    .o_pc_plus4    (o_if_id_pc_plus4),
    .o_valid       (o_if_id_valid)
  );

  assign o_pc          = r_pc;
  assign o_halted      = r_halted;
  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: reference model feeds a scoreboard queue.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam int          MEM_WORDS = 64;
  localparam logic [31:0] LIMIT     = 32'd256;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] ifi;
  logic [31:0] ifp;
  logic        ifv;
  logic        halted;
  logic [15:0] sc;

  int err_cnt = 0;
  int chk_cnt = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] p4;
    logic        v;
    logic        h;
    logic [15:0] sc;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [31:0] m_pc  = 32'h0;
  logic [31:0] m_ins = 32'h0;
  logic [31:0] m_p4  = 32'h0;
  logic        m_v   = 1'b0;
  logic        m_h   = 1'b0;
  logic [15:0] m_sc  = 16'h0;

  always #5 clk = ~clk;

  // Instruction memory: distinctive nonzero word per index, zero beyond the end.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < LIMIT) return 32'hC0DE_0000 | {24'h0, a[9:2]};
    else return 32'h0000_0000;
  endfunction

  always_comb instr = mem_word(pc);

  if_stage #(.MEM_WORDS(MEM_WORDS), .PC_RESET(32'h0000_0000)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_stall             (stall),
    .i_branch_taken      (br),
    .i_branch_target     (tgt),
    .i_instruction       (instr),
    .o_pc                (pc),
    .o_if_id_instruction (ifi),
    .o_if_id_pc_plus4    (ifp),
    .o_if_id_valid       (ifv),
    .o_halted            (halted),
    .o_stall_count       (sc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input logic r, input logic s, input logic b, input logic [31:0] t);
    logic [31:0] ta;
    ta = t & 32'hFFFF_FFFC;
    if (r) begin
      m_pc = 32'h0; m_ins = 32'h0; m_p4 = 32'h0; m_v = 1'b0; m_h = 1'b0; m_sc = 16'h0;
    end else if (b) begin
      if (s && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      m_pc = ta; m_ins = 32'h0; m_p4 = 32'h0; m_v = 1'b0;
      if (ta < LIMIT) m_h = 1'b0;
    end else if (m_h) begin
      m_ins = 32'h0; m_p4 = 32'h0; m_v = 1'b0;
    end else if (s) begin
      if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
    end else begin
      m_ins = mem_word(m_pc); m_p4 = m_pc + 32'd4; m_v = 1'b1;
      if (m_pc >= LIMIT - 32'd4) m_h = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  // Drive one cycle: push the expectation, clock, then pop and compare.
  task automatic cycle(input logic r, input logic s, input logic b, input logic [31:0] t);
    exp_t e;
    rst = r; stall = s; br = b; tgt = t;
    model_step(r, s, b, t);
    e.pc = m_pc; e.ins = m_ins; e.p4 = m_p4; e.v = m_v; e.h = m_h; e.sc = m_sc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("pc",        pc,            e.pc);
    check_eq("if_id_ins", ifi,           e.ins);
    check_eq("if_id_p4",  ifp,           e.p4);
    check_eq("if_id_v",   {31'h0, ifv},  {31'h0, e.v});
    check_eq("halted",    {31'h0, halted}, {31'h0, e.h});
    check_eq("stall_cnt", {16'h0, sc},   {16'h0, e.sc});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = 32'h0;
    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("rst_pc",    pc,  32'h0);
    check_eq("rst_valid", {31'h0, ifv}, 32'h0);
    check_eq("rst_ins",   ifi, 32'h0);

    // Free-running fetch of words 0 and 1
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("run_p4_w0", ifp, 32'd4);
    check_eq("run_ins_w0", ifi, 32'hC0DE_0000);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("run_pc_8", pc, 32'd8);

    // Three stalled cycles at pc = 8
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("stall_pc",  pc,  32'd8);
    check_eq("stall_p4",  ifp, 32'd8);
    check_eq("stall_ins", ifi, 32'hC0DE_0001);
    check_eq("stall_cnt3", {16'h0, sc}, 32'd3);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("resume_ins", ifi, 32'hC0DE_0002);
    check_eq("resume_pc",  pc,  32'd12);

    // Branch to unaligned 0x21 from pc = 12
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0021);
    check_eq("br_pc",     pc, 32'h20);
    check_eq("br_bubble", {31'h0, ifv}, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("br_tgt_ins", ifi, 32'hC0DE_0008);
    check_eq("br_tgt_p4",  ifp, 32'd36);

    // Stall and branch together: branch wins, counter still counts
    cycle(1'b0, 1'b1, 1'b1, 32'h0);
    check_eq("sb_pc",  pc, 32'h0);
    check_eq("sb_v",   {31'h0, ifv}, 32'h0);
    check_eq("sb_cnt", {16'h0, sc}, 32'd4);

    // Run to the end of memory
    for (int i = 0; i < 64; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("end_ins", ifi, 32'hC0DE_003F);
    check_eq("end_pc",  pc,  32'd252);
    check_eq("end_halt", {31'h0, halted}, 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("halt_bubble", {31'h0, ifv}, 32'h0);
    check_eq("halt_pc_hold", pc, 32'd252);
    cycle(1'b0, 1'b0, 1'b1, 32'h0);
    check_eq("unhalt", {31'h0, halted}, 32'h0);

    // Run to pc = 20 then reset mid-operation
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("pre_rst_pc", pc, 32'd20);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("midrst_pc", pc, 32'h0);
    check_eq("midrst_v",  {31'h0, ifv}, 32'h0);
    check_eq("midrst_sc", {16'h0, sc}, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("postrst_ins", ifi, 32'hC0DE_0000);

    // Branch beyond memory: last fetch registers the zero fill and halts
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0400);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("oob_halt", {31'h0, halted}, 32'h1);
    check_eq("oob_pc",   pc, 32'h400);

    // Random mix of stall, branch and occasional reset
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 11) == 0), 32'($urandom_range(0, 300)));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program counter, drives the address into the combinational instruction memory, and registers the returned word into the IF/ID pipeline register. Honours the hazard-detection stall and the branch redirect/flush, and stops fetching at the end of instruction memory. Sits between the hazard/branch logic (control inputs) and the decode stage (IF/ID outputs).

## Interface
- MEM_WORDS, 64: instruction memory depth in 32-bit words; fetch limit is MEM_WORDS*4 bytes.
- PC_RESET, 32'h0000_0000: PC value after reset.

- clk  input  1  rising-edge clock; sole clock.
- rst  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- stall  input  1  from hazard detection: hold PC and IF/ID contents.
- branch_taken  input  1  redirect request, resolved in ID.
- branch_target  input  32  redirect byte address; bits [1:0] ignored (forced 0).
- instruction  input  32  word returned combinationally by instruction memory for pc.
- pc  output  32  current fetch address to instruction memory.
- if_id_instruction  output  32  registered instruction to decode.
- if_id_pc_plus4  output  32  registered pc+4 of that instruction.
- if_id_valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
- halted  output  1  fetch has reached the end of memory.
- stall_count  output  16  saturating count of stalled cycles since reset.

## Operation
- Per-cycle priority, evaluated at posedge clk: rst > branch_taken > halted > stall > normal fetch.
- rst: pc <= PC_RESET; if_id_instruction <= 0 (NOP); if_id_pc_plus4 <= 0; if_id_valid <= 0; halted <= 0; stall_count <= 0.
- branch_taken: pc <= {branch_target[31:2],2'b00}; IF/ID loaded with bubble (instruction 0, valid 0, pc_plus4 0); halted <= 0 if target < MEM_WORDS*4. Overrides a simultaneous stall; stall_count still increments if stall is high.
- halted (and no branch): pc holds; IF/ID loaded with bubble each cycle.
- stall (no branch, not halted): pc and all IF/ID outputs hold; stall_count increments, saturating at 16'hFFFF.
- Normal: if_id_instruction <= instruction; if_id_pc_plus4 <= pc+4; if_id_valid <= 1; pc <= pc+4.
- End of memory: when pc+4 would equal or exceed MEM_WORDS*4 on a normal fetch, the last word is still registered, pc holds at its value, halted <= 1 (sticky). pc never wraps.
- Arithmetic: all PC math 32-bit unsigned, modulo 2^32; pc[1:0] always 0.
- Bubble encoding is the all-zero word (sll $0,$0,0), matching the memory fill value.

## Timing
- Fetch latency: instruction at address A appears on if_id_instruction one cycle after pc = A.
- Branch penalty: one bubble; target instruction appears in IF/ID two edges after branch_taken is sampled.
- stall is level-sensitive; each high cycle freezes exactly one fetch.
- Reset mid-operation: next edge discards any in-flight IF/ID content and clears halted; first valid instruction (word 0) appears one cycle after rst deasserts.
- rst must be held at least one cycle so instruction memory contents are loaded before fetch.
- All outputs registered except pc, which is the PC register itself.

## Structure
- Shared package: NOP_WORD (32'h0), INSTR_W (32), PC_STEP (4), PC_RESET default.
- One sub-module natural: if_id_reg (IF/ID register with load-enable for stall and synchronous flush-to-bubble); PC register, halt flag and stall counter stay in if_stage.

## Test plan
- Reset then 4 free-running cycles -> pc = 0,4,8,12,16; if_id_pc_plus4 = 4,8,12,16; if_id_valid = 1 from cycle 1; IF/ID outputs 0 and valid 0 during reset.
- Stall high 3 cycles at pc = 8 -> pc stays 8, IF/ID holds word 1 (pc_plus4 = 8), stall_count = 3; resumes with word 2.
- branch_taken with target 32'h0000_0021 at pc = 12 -> next pc = 32'h20, one bubble (valid 0), then word 8 with pc_plus4 = 36.
- stall and branch_taken together, target 0 -> pc = 0, bubble inserted, stall_count increments by 1.
- MEM_WORDS = 64, run to pc = 252 -> word 63 registered, pc holds 252, halted = 1, bubbles thereafter; branch to 0 clears halted.
- rst asserted at pc = 20 with valid IF/ID -> next edge pc = 0, valid 0, halted 0, stall_count 0.
